// File: rtl/fpu_sp_sub_if.sv
// Handshake and operand/result bundle for the sequential single-precision subtractor.
// The master modport belongs to the FPU controller; the slave modport belongs to the subtractor.
interface fpu_sp_sub_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        overflow_underflow_flag;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b,
    input  result, overflow_underflow_flag, busy, done
  );

  modport slave (
    input  start, a, b,
    output result, overflow_underflow_flag, busy, done
  );
endinterface

// File: rtl/fpu_sp_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor: result = a - b.
// The subtraction is carried out as an addition with b's sign flipped. Alignment and
// normalization are iterative, so latency trades against area.
// Optional macro FPU_SUB_BARREL_ALIGN_EN: the whole alignment shift happens in one ALIGN cycle.
// With the macro undefined, Y shifts one bit per cycle. NORM is serial in both builds.
module fpu_sp_sub_seq (
  input  logic         clk,
  input  logic         rst,
  fpu_sp_sub_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sx_q, sx_d, sy_q, sy_d;       // signs of larger (X) and smaller (Y) operand
  logic [9:0]  ex_q, ex_d;                   // working exponent, headroom for carry
  logic [26:0] mx_q, mx_d, my_q, my_d;       // {hidden+frac[23:0], guard, round, sticky}
  logic [4:0]  cnt_q, cnt_d;                 // remaining alignment shift
  logic        nan_q, nan_d, zero_q, zero_d;
  logic [31:0] result_q, result_d;
  logic        flag_q, flag_d, busy_q, busy_d, done_q, done_d;

  // Unpack helpers: exponent-0 operands flush to zero, b's sign is flipped.
  logic [7:0]  ea, eb;
  logic [30:0] mag_a, mag_b;
  logic [23:0] ma, mb;
  logic        swap, nan_in;
  logic [7:0]  ex_big, ex_small;
  logic [8:0]  ediff;
  assign ea       = a_q[30:23];
  assign eb       = b_q[30:23];
  assign mag_a    = (ea == 8'd0) ? 31'd0 : a_q[30:0];
  assign mag_b    = (eb == 8'd0) ? 31'd0 : b_q[30:0];
  assign ma       = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
  assign mb       = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
  assign swap     = mag_b > mag_a;
  assign nan_in   = (ea == 8'hFF) || (eb == 8'hFF);
  assign ex_big   = swap ? eb : ea;
  assign ex_small = swap ? ea : eb;
  assign ediff    = {1'b0, ex_big} - {1'b0, ex_small};

`ifdef FPU_SUB_BARREL_ALIGN_EN
  // Full-width alignment: bits pushed past position 0 collapse into sticky.
  logic [26:0] shr, lost, my_aligned;
  assign shr        = my_q >> cnt_q;
  assign lost       = my_q << (5'd27 - cnt_q);
  assign my_aligned = {shr[26:1], shr[0] | (|lost)};
`endif

  // Effective addition of the aligned mantissas; X magnitude >= Y so subtraction never wraps.
  logic [27:0] sum;
  assign sum = (sx_q == sy_q) ? ({1'b0, mx_q} + {1'b0, my_q})
                              : ({1'b0, mx_q} - {1'b0, my_q});

  // Round to nearest even on guard/round/sticky, renormalizing on mantissa carry.
  logic        rnd_up;
  logic [24:0] mant_r;
  logic [9:0]  exp_r;
  logic [22:0] frac_r;
  logic [31:0] packed_res;
  logic        packed_flag;
  assign rnd_up = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
  assign mant_r = {1'b0, mx_q[26:3]} + {24'd0, rnd_up};
  assign exp_r  = ex_q + {9'd0, mant_r[24]};
  assign frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

  // Final packing including special cases (NaN/inf input, exact zero, overflow, underflow).
  always_comb begin
    packed_res  = {sx_q, exp_r[7:0], frac_r};
    packed_flag = 1'b0;
    if (nan_q) begin
      packed_res  = 32'h7FC0_0000;
      packed_flag = 1'b1;
    end else if (zero_q) begin
      packed_res  = 32'h0000_0000;
    end else if (exp_r >= 10'd255) begin
      packed_res  = {sx_q, 8'hFF, 23'd0};
      packed_flag = 1'b1;
    end else if (exp_r == 10'd0) begin
      packed_res  = {sx_q, 31'd0};
      packed_flag = 1'b1;
    end
  end

  // Next-state and datapath sequencing for the whole operation.
  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    ex_d     = ex_q;
    mx_d     = mx_q;
    my_d     = my_q;
    cnt_d    = cnt_q;
    nan_d    = nan_q;
    zero_d   = zero_q;
    result_d = result_q;
    flag_d   = flag_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sx_d   = swap ? ~b_q[31] : a_q[31];
        sy_d   = swap ? a_q[31] : ~b_q[31];
        ex_d   = {2'b00, ex_big};
        mx_d   = swap ? {mb, 3'b000} : {ma, 3'b000};
        my_d   = swap ? {ma, 3'b000} : {mb, 3'b000};
        cnt_d  = (ediff > 9'd27) ? 5'd27 : ediff[4:0];
        if (nan_in) cnt_d = 5'd1;
        nan_d  = nan_in;
        zero_d = 1'b0;
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
`ifdef FPU_SUB_BARREL_ALIGN_EN
        my_d    = my_aligned;
        cnt_d   = 5'd0;
        state_d = S_ADD;
`else
        if (cnt_q != 5'd0) begin
          my_d  = {1'b0, my_q[26:2], my_q[1] | my_q[0]};
          cnt_d = cnt_q - 5'd1;
        end
        if (cnt_q <= 5'd1) state_d = S_ADD;
`endif
      end
      S_ADD: begin
        if (nan_q) begin
          state_d = S_ROUND;
        end else if (sum == 28'd0) begin
          zero_d  = 1'b1;
          state_d = S_ROUND;
        end else if (sum[27]) begin
          mx_d    = {sum[27:2], sum[1] | sum[0]};
          ex_d    = ex_q + 10'd1;
          state_d = S_ROUND;
        end else begin
          mx_d    = sum[26:0];
          state_d = (sum[26] || ex_q == 10'd0) ? S_ROUND : S_NORM;
        end
      end
      S_NORM: begin
        mx_d = {mx_q[25:0], 1'b0};
        ex_d = ex_q - 10'd1;
        if (mx_q[25] || ex_q == 10'd1) state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d = packed_res;
        flag_d   = packed_flag;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      ex_q     <= '0;
      mx_q     <= '0;
      my_q     <= '0;
      cnt_q    <= '0;
      nan_q    <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= 32'h0000_0000;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      ex_q     <= ex_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      cnt_q    <= cnt_d;
      nan_q    <= nan_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result                  = result_q;
  assign bus.overflow_underflow_flag = flag_q;
  assign bus.busy                    = busy_q;
  assign bus.done                    = done_q;

endmodule

// File: tb/tb_fpu_sp_sub_seq.sv
// Directed self-checking bench for fpu_sp_sub_seq: results, flags, latency and handshake.
module tb_fpu_sp_sub_seq;

  logic clk;
  logic rst;
  int   passed;
  int   total;

`ifdef FPU_SUB_BARREL_ALIGN_EN
  localparam int LAT_GAP = 5;
`else
  localparam int LAT_GAP = 28;
`endif

  fpu_sp_sub_if bus ();

  fpu_sp_sub_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present operands with start high; returns just after the capture edge with start low.
  task automatic launch(input logic [31:0] av, input logic [31:0] bv);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts cycles after the capture edge until done; ends on the negedge of the done cycle.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                    input logic [31:0] exp_res, input logic exp_flag, input int exp_lat);
    int lat;
    @(negedge clk);
    launch(av, bv);
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, bus.result, exp_res);
    check({tag, "_flag"}, {31'd0, bus.overflow_underflow_flag}, {31'd0, exp_flag});
    check({tag, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int dn;
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result", bus.result, 32'h0000_0000);
    check("rst_flag", {31'd0, bus.overflow_underflow_flag}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;

    // Basic function, wide exponent gap, exact cancellation.
    op("simple", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 4);
    op("gap", 32'h4B80_0000, 32'h3F80_0000, 32'h4B7F_FFFF, 1'b0, LAT_GAP);
    op("cancel1", 32'h8820_0010, 32'h8820_0010, 32'h0000_0000, 1'b0, 4);
    op("cancel2", 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 4);

    // Overflow and underflow, each from reset.
    do_reset();
    op("ovf", 32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b1, 4);
    do_reset();
    op("unf", 32'h0080_0000, 32'h0080_0001, 32'h8000_0000, 1'b1, 5);

    // NaN input propagates as the canonical quiet NaN.
    op("nan", 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 4);

    // start pulsed mid-operation is ignored: exactly one done pulse.
    @(negedge clk);
    launch(32'h4040_0000, 32'h3F80_0000);
    @(negedge clk);
    check("mid_busy", {31'd0, bus.busy}, 32'd1);
    launch(32'h7F7F_FFFF, 32'hFF7F_FFFF);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    check("mid_done_count", dn, 32'd1);
    check("mid_res", bus.result, 32'h4000_0000);
    check("mid_flag", {31'd0, bus.overflow_underflow_flag}, 32'd0);

    // start in the done cycle launches the next operation with no bubble.
    @(negedge clk);
    launch(32'h4040_0000, 32'h3F80_0000);
    wait_done(lat);
    check("b2b_first_lat", lat, 32'd4);
    check("b2b_first_res", bus.result, 32'h4000_0000);
    launch(32'h4B80_0000, 32'h3F80_0000);
    @(negedge clk);
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    check("b2b_second_lat", lat + 1, LAT_GAP);
    check("b2b_second_res", bus.result, 32'h4B7F_FFFF);

    // Reset while in ALIGN aborts with no done pulse.
    @(negedge clk);
    launch(32'h4B80_0000, 32'h3F80_0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    check("abort_no_done", dn, 32'd0);
    check("abort_result_held", bus.result, 32'h0000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
